dtw_traceback: RTL
==================

DTW_TRACEBACK -- requirements
Module: dtw_traceback

Interface
REQ-001 Parameter MAXLEN, default 32: max sequence length; index width 5 bits.
REQ-002 Parameter NPE, default 6: number of systolic PEs feeding per-cycle path bits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 nrst  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  capture enable; path bits written only when high.
REQ-006 i_path  input  12  2 bits per PE, PE0 at [11:10]; 00 diag (t-1,r-1), 01 from (t-1,r), 10 from (t,r-1), 11 origin/invalid.
REQ-007 i_tindex  input  30  5-bit T index per PE, PE0 at [29:25].
REQ-008 i_rindex  input  30  5-bit R index per PE, PE0 at [29:25].
REQ-009 i_pvalid  input  6  per-PE cell-valid flag, PE0 at bit 5.
REQ-010 start  input  1  single-cycle request to begin traceback.
REQ-011 tlast, rlast  input  5 each  final T and R indices (end cell).
REQ-012 step_ready  input  1  consumer accepts current step.
REQ-013 step_valid  output  1  step_t/step_r/step_dir hold a valid step.
REQ-014 step_t, step_r  output  5 each  coordinates of current path cell.
REQ-015 step_dir  output  2  stored direction of that cell.
REQ-016 busy  output  1  high in TRACE.
REQ-017 done  output  1  one-cycle pulse after last step accepted.
REQ-018 err  output  1  sticky; set on invalid direction during trace, cleared by next accepted start.

Function
REQ-019 Direction store SHALL be MAXLEN x MAXLEN x 2 bits, addressed (t,r).
REQ-020 In IDLE with ena=1, each PE i with i_pvalid[i]=1 SHALL write its 2 bits to (tindex_i, rindex_i) at the clock edge.
REQ-021 Two PEs addressing the same cell in one cycle: higher PE number (lower bit position) SHALL win.
REQ-022 Writes SHALL be ignored while busy=1.
REQ-023 FSM states IDLE, TRACE, FIN; reset state IDLE.
REQ-024 IDLE->TRACE on start=1; cursor loaded with (tlast, rlast); start ignored outside IDLE.
REQ-025 step_valid SHALL rise the cycle after start is sampled (latency 1) and remain high until handshake.
REQ-026 Outputs SHALL be registered and stable while step_valid=1 and step_ready=0.
REQ-027 On handshake (step_valid & step_ready), cursor SHALL move per stored dir: 00 -> (t-1,r-1), 01 -> (t-1,r), 10 -> (t,r-1); next step presented the following cycle.
REQ-028 Boundary: t=0 with dir 00/01 SHALL move to (0,r-1); r=0 with dir 00/10 SHALL move to (t-1,0); no wrap-around permitted.
REQ-029 Cell (0,0) accepted -> FIN; also dir 11 at a cell other than (0,0) accepted -> set err, FIN.
REQ-030 FIN SHALL assert done for exactly one cycle, deassert step_valid, then return to IDLE.
REQ-031 Maximum step count SHALL be tlast+rlast+1; no step counter overflow.

Reset
REQ-032 nrst low SHALL asynchronously force IDLE, step_valid=0, busy=0, done=0, err=0, step_t=step_r=0, step_dir=2'b11.
REQ-033 Direction store SHALL reset to 2'b11 in every cell; reset mid-trace aborts with no done pulse.

Structure
REQ-034 Shared package SHALL hold direction encodings (DIR_DIAG, DIR_T, DIR_R, DIR_ORG), FSM state enum, MAXLEN, NPE, index width.
REQ-035 Direction store SHALL be a separate sub-module dtw_path_mem (NPE write ports, one combinational read port).
REQ-036 FSM, cursor and output registers SHALL reside in dtw_traceback.

Verification
REQ-037 Capture diag 00 at (k,k) k=0..4, start with tlast=rlast=4, ready=1 -> steps (4,4),(3,3),(2,2),(1,1),(0,0), then done pulse, err=0.
REQ-038 Write PE0 dir 01 and PE5 dir 10 to (3,3) same cycle -> readback in trace shows dir 10 at (3,3).
REQ-039 Stored dir 00 at (0,2) during trace -> next step (0,1), not wrap to (31,1).
REQ-040 step_ready held low 5 cycles at (2,1) -> outputs unchanged, cursor unchanged, then advance on ready.
REQ-041 Unwritten cell (2,2) reached (dir 11) -> err=1, done pulse, return IDLE; capture with ena=1 during trace -> store unchanged.
REQ-042 nrst asserted mid-trace -> immediate step_valid=0, busy=0, all cells read 11 on next trace.

Source files
------------

// File: rtl/dtw_traceback_pkg.sv
// ============================================================================
// Module      : dtw_traceback_pkg
// Description : Shared constants, direction encodings and FSM state type for
//               the DTW traceback block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtw_traceback_pkg;

    localparam int DTW_MAXLEN = 32;
    localparam int DTW_NPE    = 6;
    localparam int DTW_IDX_W  = 5;

    // Predecessor encodings as produced by the systolic array
    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_T    = 2'b01;
    localparam logic [1:0] DIR_R    = 2'b10;
    localparam logic [1:0] DIR_ORG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACE = 2'd1,
        ST_FIN   = 2'd2
    } dtw_state_t;

endpackage

`default_nettype wire

// File: rtl/dtw_path_mem.sv
// ============================================================================
// Module      : dtw_path_mem
// Description : MAXLEN x MAXLEN x 2-bit direction store with NPE write ports
//               and one combinational read port; resets every cell to origin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtw_path_mem
    import dtw_traceback_pkg::*;
#(
    parameter int MAXLEN = DTW_MAXLEN,
    parameter int NPE    = DTW_NPE
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       we,
    input  logic [2*NPE-1:0]           wr_path,
    input  logic [DTW_IDX_W*NPE-1:0]   wr_tindex,
    input  logic [DTW_IDX_W*NPE-1:0]   wr_rindex,
    input  logic [NPE-1:0]             wr_valid,
    input  logic [DTW_IDX_W-1:0]       rd_t,
    input  logic [DTW_IDX_W-1:0]       rd_r,
    output logic [1:0]                 rd_dir
);

    logic [1:0]           r_mem   [0:MAXLEN-1][0:MAXLEN-1];
    logic [1:0]           w_pe_dir[NPE];
    logic [DTW_IDX_W-1:0] w_pe_t  [NPE];
    logic [DTW_IDX_W-1:0] w_pe_r  [NPE];
    logic                 w_pe_vld[NPE];

    // PE0 occupies the most significant field of every packed bus
    for (genvar p = 0; p < NPE; p++) begin : g_pe
        assign w_pe_dir[p] = wr_path  [2*(NPE-1-p) +: 2];
        assign w_pe_t[p]   = wr_tindex[DTW_IDX_W*(NPE-1-p) +: DTW_IDX_W];
        assign w_pe_r[p]   = wr_rindex[DTW_IDX_W*(NPE-1-p) +: DTW_IDX_W];
        assign w_pe_vld[p] = wr_valid [NPE-1-p];
    end

    // Ascending PE order: a later (higher-numbered) PE overrides an earlier one
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int t = 0; t < MAXLEN; t++) begin
                for (int r = 0; r < MAXLEN; r++) begin
                    r_mem[t][r] <= DIR_ORG;
                end
            end
        end else if (we) begin
            for (int p = 0; p < NPE; p++) begin
                if (w_pe_vld[p] && (int'(w_pe_t[p]) < MAXLEN) && (int'(w_pe_r[p]) < MAXLEN)) begin
                    r_mem[w_pe_t[p]][w_pe_r[p]] <= w_pe_dir[p];
                end
            end
        end
    end

    always_comb begin
        rd_dir = DIR_ORG;
        if ((int'(rd_t) < MAXLEN) && (int'(rd_r) < MAXLEN)) begin
            rd_dir = r_mem[rd_t][rd_r];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dtw_traceback.sv
// ============================================================================
// Module      : dtw_traceback
// Description : Captures per-cell DTW predecessor directions and walks the
//               optimal path from (tlast,rlast) back to (0,0) with a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtw_traceback
    import dtw_traceback_pkg::*;
#(
    parameter int MAXLEN = DTW_MAXLEN,
    parameter int NPE    = DTW_NPE
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       ena,
    input  logic [2*NPE-1:0]           i_path,
    input  logic [DTW_IDX_W*NPE-1:0]   i_tindex,
    input  logic [DTW_IDX_W*NPE-1:0]   i_rindex,
    input  logic [NPE-1:0]             i_pvalid,
    input  logic                       start,
    input  logic [DTW_IDX_W-1:0]       tlast,
    input  logic [DTW_IDX_W-1:0]       rlast,
    input  logic                       step_ready,
    output logic                       step_valid,
    output logic [DTW_IDX_W-1:0]       step_t,
    output logic [DTW_IDX_W-1:0]       step_r,
    output logic [1:0]                 step_dir,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    dtw_state_t           r_state, w_state_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [DTW_IDX_W-1:0] r_t, w_t_nxt;
    logic [DTW_IDX_W-1:0] r_r, w_r_nxt;
    logic [1:0]           r_dir, w_dir_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;

    logic [DTW_IDX_W-1:0] w_mv_t, w_mv_r;
    logic [DTW_IDX_W-1:0] w_rd_t, w_rd_r;
    logic [1:0]           w_rd_dir;
    logic                 w_we;
    logic                 w_hs;
    logic                 w_at_origin;

    assign w_we        = ena && (r_state == ST_IDLE);
    assign w_hs        = r_valid && step_ready;
    assign w_at_origin = (r_t == '0) && (r_r == '0);

    dtw_path_mem #(
        .MAXLEN (MAXLEN),
        .NPE    (NPE)
    ) u_path_mem (
        .clk       (clk),
        .nrst      (nrst),
        .we        (w_we),
        .wr_path   (i_path),
        .wr_tindex (i_tindex),
        .wr_rindex (i_rindex),
        .wr_valid  (i_pvalid),
        .rd_t      (w_rd_t),
        .rd_r      (w_rd_r),
        .rd_dir    (w_rd_dir)
    );

    // Predecessor of the current cell; an exhausted axis collapses the move
    // onto the other axis so the cursor can never wrap past zero.
    always_comb begin
        w_mv_t = r_t;
        w_mv_r = r_r;
        unique case (r_dir)
            DIR_DIAG: begin
                if (r_t == '0) begin
                    w_mv_r = r_r - 1'b1;
                end else if (r_r == '0) begin
                    w_mv_t = r_t - 1'b1;
                end else begin
                    w_mv_t = r_t - 1'b1;
                    w_mv_r = r_r - 1'b1;
                end
            end
            DIR_T: begin
                if (r_t == '0) begin
                    w_mv_r = r_r - 1'b1;
                end else begin
                    w_mv_t = r_t - 1'b1;
                end
            end
            DIR_R: begin
                if (r_r == '0) begin
                    w_mv_t = r_t - 1'b1;
                end else begin
                    w_mv_r = r_r - 1'b1;
                end
            end
            default: begin
                w_mv_t = r_t;
                w_mv_r = r_r;
            end
        endcase
    end

    // Look ahead to the cell that will be presented next so step_dir registers with it
    assign w_rd_t = (r_state == ST_IDLE) ? tlast : w_mv_t;
    assign w_rd_r = (r_state == ST_IDLE) ? rlast : w_mv_r;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_t_nxt     = r_t;
        w_r_nxt     = r_r;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_TRACE;
                    w_valid_nxt = 1'b1;
                    w_t_nxt     = tlast;
                    w_r_nxt     = rlast;
                    w_dir_nxt   = w_rd_dir;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_TRACE: begin
                if (w_hs) begin
                    if (w_at_origin || (r_dir == DIR_ORG)) begin
                        w_state_nxt = ST_FIN;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        if (!w_at_origin) begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_t_nxt   = w_mv_t;
                        w_r_nxt   = w_mv_r;
                        w_dir_nxt = w_rd_dir;
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_t     <= '0;
            r_r     <= '0;
            r_dir   <= DIR_ORG;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_t     <= w_t_nxt;
            r_r     <= w_r_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign step_valid = r_valid;
    assign step_t     = r_t;
    assign step_r     = r_r;
    assign step_dir   = r_dir;
    assign busy       = (r_state == ST_TRACE);
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire
